sync_fifo_lvl: RTL and testbench
================================

// Module: sync_fifo_lvl
// PURPOSE
//   Single-clock first-word-fall-through (FWFT) FIFO with fill level, almost-full/empty and sticky error flags.
//   Storage/responder end of the fifo_wen/fifo_ren write/read protocol driven by block-level producers and consumers.
//   Drop-in target for the existing sync FIFO bench port list, with level/status ports added.
// PARAMETERS
//   FIFO_WIDTH     8   data word width, bits
//   FIFO_DEPTH     8   entries; power of 2, >= 2
//   AFULL_THRESH   6   fifo_afull asserted when count >= AFULL_THRESH (1..FIFO_DEPTH)
//   AEMPTY_THRESH  2   fifo_aempty asserted when count <= AEMPTY_THRESH (0..FIFO_DEPTH-1)
// PORTS
//   fifo_clk      in   1                   clock, rising edge
//   fifo_rst_n    in   1                   reset, asynchronous, active-high
//   fifo_wen      in   1                   write request
//   fifo_wdata    in   FIFO_WIDTH          write data
//   fifo_full     out  1                   count == FIFO_DEPTH
//   fifo_afull    out  1                   count >= AFULL_THRESH
//   fifo_ren      in   1                   read/pop request
//   fifo_rdata    out  FIFO_WIDTH          head word (FWFT); 0 when empty
//   fifo_empty    out  1                   count == 0
//   fifo_aempty   out  1                   count <= AEMPTY_THRESH
//   fifo_count    out  $clog2(DEPTH)+1     current occupancy, 0..FIFO_DEPTH
//   fifo_ovf      out  1                   sticky: write rejected
//   fifo_udf      out  1                   sticky: read on empty
//   fifo_err_clr  in   1                   sync clear of fifo_ovf/fifo_udf
// BEHAVIOUR
//   Reset (fifo_rst_n=1, async, any cycle incl. mid-burst):
//     - wr_ptr=rd_ptr=0, count=0.
//     - Output values: empty=1, aempty=1, full=0, afull=0, ovf=0, udf=0, rdata=0.
//     - Memory contents are not reset.
//   Pointers: PTR_W=$clog2(DEPTH) bits each, wrap DEPTH-1 -> 0. count is held in a register; pointers are not compared.
//   Accept rules, evaluated on the same edge:
//     - rd_acc = fifo_ren & ~empty.
//     - wr_acc = fifo_wen & (~full | fifo_ren). Full plus simultaneous read: both accepted, count unchanged.
//     - Empty plus simultaneous read and write: write accepted, read ignored, udf set, count -> 1.
//   Update: mem[wr_ptr]<=wdata and wr_ptr++ on wr_acc. rd_ptr++ on rd_acc. count <= count + wr_acc - rd_acc.
//   Flags: full/empty/afull/aempty are decoded from the registered count. No combinational path from wen/ren.
//   FWFT latency:
//     - A word written at edge k appears on rdata and deasserts empty after edge k (1 cycle).
//     - Pop at edge k shows the next word after edge k.
//   rdata = empty ? '0 : mem[rd_ptr] (asynchronous read of registered storage).
//   Errors:
//     - ovf <= 1 on fifo_wen & full & ~fifo_ren.
//     - udf <= 1 on fifo_ren & empty.
//     - Both hold until fifo_err_clr=1. If a set and a clear occur in the same cycle, set wins.
//   Rejected ops change no pointer, no count, no memory.
// STRUCTURE
//   sync_fifo_pkg: clog2-derived PTR_W/CNT_W localparams helper, fifo_status_t struct {full,afull,empty,aempty,ovf,udf}.
//   Sub-module sync_fifo_ram: DEPTH x WIDTH array, sync write (we, waddr, wdata), async read (raddr -> rdata).
//   Top: pointers, count, flag decode, error flags.
// TESTING
//   1 Reset: after reset -> empty=1, aempty=1, count=0, rdata=00, ovf=udf=0. Mid-stream reset at count=5 -> same values immediately.
//   2 Fill: 8 writes 00..07 with ren=0 -> count 1..8; afull at count 6; full at 8. A 9th write (AA) -> ovf=1, count=8, rdata stays 00.
//   3 Drain: 8 reads from full -> rdata 00..07 in order; empty=1 after last. A further ren -> udf=1, count=0.
//   4 Simultaneous read+write at full: wdata=08 with ren -> count=8, no ovf, 08 read after 01..07.
//   5 Empty plus read+write: wdata=5A -> count=1, udf=1, rdata=5A next cycle. err_clr -> ovf=udf=0.
//   6 Streaming: random wen/ren for 1000 cycles against a scoreboard.
//     - Data order is preserved across pointer wrap.
//     - count equals the model every cycle.
//     - ovf/udf stay 0 when the bench obeys full/empty.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types and width helpers for the single-clock FWFT FIFO.
package sync_fifo_pkg;

  // Status flags as seen at the FIFO boundary.
  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
    logic ovf;
    logic udf;
  } fifo_status_t;

  // Pointer width; a depth of 1 would otherwise give a zero-width pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // The count needs one extra bit to hold the value DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read. Contents are never reset.
module sync_fifo_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on accepted writes only.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock first-word-fall-through FIFO with fill level, almost-full/empty
// thresholds and sticky overflow/underflow flags.
module sync_fifo_lvl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned AFULL_THRESH  = 6,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                              fifo_clk,
  input  logic                              fifo_rst_n,
  input  logic                              fifo_wen,
  input  logic [FIFO_WIDTH-1:0]             fifo_wdata,
  output logic                              fifo_full,
  output logic                              fifo_afull,
  input  logic                              fifo_ren,
  output logic [FIFO_WIDTH-1:0]             fifo_rdata,
  output logic                              fifo_empty,
  output logic                              fifo_aempty,
  output logic [cnt_width(FIFO_DEPTH)-1:0]  fifo_count,
  output logic                              fifo_ovf,
  output logic                              fifo_udf,
  input  logic                              fifo_err_clr
);

  localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, udf_q, ovf_d, udf_d;
  logic                  wr_acc, rd_acc;
  logic [FIFO_WIDTH-1:0] ram_rdata;
  fifo_status_t          status;

  // Flag decode from the registered count only; no path from wen/ren.
  always_comb begin
    status        = '0;
    status.full   = (count_q == CNT_W'(FIFO_DEPTH));
    status.afull  = (count_q >= CNT_W'(AFULL_THRESH));
    status.empty  = (count_q == '0);
    status.aempty = (count_q <= CNT_W'(AEMPTY_THRESH));
    status.ovf    = ovf_q;
    status.udf    = udf_q;
  end

  // A write at full is accepted only when a pop frees a slot on the same edge.
  // A read at empty is never accepted, even alongside a write.
  assign rd_acc = fifo_ren & ~status.empty;
  assign wr_acc = fifo_wen & (~status.full | fifo_ren);

  // Next count and sticky error flags; a set beats a same-cycle clear.
  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = (fifo_wen & status.full & ~fifo_ren) | (ovf_q & ~fifo_err_clr);
    udf_d = (fifo_ren & status.empty) | (udf_q & ~fifo_err_clr);
  end

  // Pointer, count and error state; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge fifo_clk or posedge fifo_rst_n) begin
    if (fifo_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  sync_fifo_ram #(
    .WIDTH  (FIFO_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (fifo_clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (fifo_wdata),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Head word falls through; forced to zero while empty.
  assign fifo_rdata  = status.empty ? '0 : ram_rdata;
  assign fifo_full   = status.full;
  assign fifo_afull  = status.afull;
  assign fifo_empty  = status.empty;
  assign fifo_aempty = status.aempty;
  assign fifo_ovf    = status.ovf;
  assign fifo_udf    = status.udf;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed plus random bench for sync_fifo_lvl with a queue-based reference model.
module tb_sync_fifo_lvl;

  localparam int unsigned W     = 8;
  localparam int unsigned D     = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 2;
  localparam int unsigned CNT_W = $clog2(D) + 1;

  logic             fifo_clk = 1'b0;
  logic             fifo_rst_n = 1'b1;
  logic             fifo_wen = 1'b0;
  logic [W-1:0]     fifo_wdata = '0;
  logic             fifo_full, fifo_afull;
  logic             fifo_ren = 1'b0;
  logic [W-1:0]     fifo_rdata;
  logic             fifo_empty, fifo_aempty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_ovf, fifo_udf;
  logic             fifo_err_clr = 1'b0;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model state.
  logic [W-1:0] q[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;

  sync_fifo_lvl #(
    .FIFO_WIDTH    (W),
    .FIFO_DEPTH    (D),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .fifo_clk     (fifo_clk),
    .fifo_rst_n   (fifo_rst_n),
    .fifo_wen     (fifo_wen),
    .fifo_wdata   (fifo_wdata),
    .fifo_full    (fifo_full),
    .fifo_afull   (fifo_afull),
    .fifo_ren     (fifo_ren),
    .fifo_rdata   (fifo_rdata),
    .fifo_empty   (fifo_empty),
    .fifo_aempty  (fifo_aempty),
    .fifo_count   (fifo_count),
    .fifo_ovf     (fifo_ovf),
    .fifo_udf     (fifo_udf),
    .fifo_err_clr (fifo_err_clr)
  );

  always #5 fifo_clk = ~fifo_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_head();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  // {full, afull, empty, aempty, ovf, udf} from the model.
  function automatic logic [5:0] exp_status();
    int c = q.size();
    return {c == D, c >= AF, c == 0, c <= AE, m_ovf, m_udf};
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
    check({tag, "_rdata"}, 32'(fifo_rdata), 32'(exp_head()));
    check({tag, "_status"},
          32'({fifo_full, fifo_afull, fifo_empty, fifo_aempty, fifo_ovf, fifo_udf}),
          32'(exp_status()));
  endtask

  // One clock: drive, check head before the edge (the popped word), step model, check after.
  task automatic cycle(input string tag, input logic wen, input logic [W-1:0] wd,
                       input logic ren, input logic clr);
    logic rd_acc, wr_acc, set_ovf, set_udf;
    int   c;
    fifo_wen     = wen;
    fifo_wdata   = wd;
    fifo_ren     = ren;
    fifo_err_clr = clr;
    c       = q.size();
    rd_acc  = ren && (c > 0);
    wr_acc  = wen && ((c < D) || ren);
    set_ovf = wen && (c == D) && !ren;
    set_udf = ren && (c == 0);
    if (rd_acc) check({tag, "_pop"}, 32'(fifo_rdata), 32'(q[0]));
    @(posedge fifo_clk);
    if (rd_acc) void'(q.pop_front());
    if (wr_acc) q.push_back(wd);
    m_ovf = set_ovf || (m_ovf && !clr);
    m_udf = set_udf || (m_udf && !clr);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    // 1: reset state
    #12;
    check_outputs("rst");
    fifo_rst_n = 1'b0;
    @(posedge fifo_clk);
    #1;
    check_outputs("rst_rel");

    // Mid-stream reset at count 5, applied between edges.
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    check("mid_cnt5", 32'(fifo_count), 32'd5);
    #2;
    fifo_wen   = 1'b0;
    fifo_rst_n = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_outputs("mid_rst");
    check("mid_rst_empty", 32'(fifo_empty), 32'd1);
    @(negedge fifo_clk);
    fifo_rst_n = 1'b0;
    @(posedge fifo_clk);
    #1;

    // 2: fill 00..07, then a rejected 9th write
    for (int i = 0; i < 8; i++) begin
      cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
      check("fill_cnt", 32'(fifo_count), 32'(i + 1));
    end
    check("fill_full", 32'(fifo_full), 32'd1);
    cycle("ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_flag", 32'(fifo_ovf), 32'd1);
    check("ovf_rdata", 32'(fifo_rdata), 32'h00);

    // 3: drain in order, then an extra read underflows
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_empty", 32'(fifo_empty), 32'd1);
    cycle("udf", 1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_flag", 32'(fifo_udf), 32'd1);
    check("udf_cnt", 32'(fifo_count), 32'd0);
    cycle("clr1", 1'b0, 8'h00, 1'b0, 1'b1);

    // 4: read+write at full
    for (int i = 0; i < 8; i++) cycle("refill", 1'b1, 8'(i), 1'b0, 1'b0);
    cycle("rw_full", 1'b1, 8'h08, 1'b1, 1'b0);
    check("rw_full_cnt", 32'(fifo_count), 32'd8);
    check("rw_full_ovf", 32'(fifo_ovf), 32'd0);
    for (int i = 0; i < 8; i++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    // 5: read+write at empty, then clear
    cycle("rw_empty", 1'b1, 8'h5A, 1'b1, 1'b0);
    check("rw_empty_cnt", 32'(fifo_count), 32'd1);
    check("rw_empty_udf", 32'(fifo_udf), 32'd1);
    check("rw_empty_rdata", 32'(fifo_rdata), 32'h5A);
    cycle("set_ovf", 1'b0, 8'h00, 1'b1, 1'b1);
    cycle("clr2", 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_flags", 32'({fifo_ovf, fifo_udf}), 32'd0);
    // A set in the same cycle as a clear wins.
    cycle("set_wins", 1'b0, 8'h00, 1'b1, 1'b1);
    check("set_wins_udf", 32'(fifo_udf), 32'd1);
    cycle("clr3", 1'b0, 8'h00, 1'b0, 1'b1);

    // 6: random streaming obeying full/empty
    for (int i = 0; i < 1000; i++) begin
      logic wen, ren;
      wen = ($urandom_range(0, 99) < 55) && (q.size() < D);
      ren = ($urandom_range(0, 99) < 50) && (q.size() > 0);
      cycle("stream", wen, 8'($urandom), ren, 1'b0);
    end
    check("stream_ovf", 32'(fifo_ovf), 32'd0);
    check("stream_udf", 32'(fifo_udf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
